// File: rtl/alu_pkg.sv
// Shared encodings for the sequential RV32IM execute ALU: funct3/funct7 values and FSM states.
package alu_pkg;

  localparam logic [2:0] F3_ADD    = 3'b000;
  localparam logic [2:0] F3_SLL    = 3'b001;
  localparam logic [2:0] F3_SLT    = 3'b010;
  localparam logic [2:0] F3_SLTU   = 3'b011;
  localparam logic [2:0] F3_XOR    = 3'b100;
  localparam logic [2:0] F3_SR     = 3'b101;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] F7_BASE   = 7'h00;
  localparam logic [6:0] F7_ALT    = 7'h20;
  localparam logic [6:0] F7_MULDIV = 7'h01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_muldiv_seq_if.sv
// Operation/result handshake bundle between register-read, the ALU and writeback.
interface alu_muldiv_seq_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] reg_source1;
  logic [XLEN-1:0] reg_source2;
  logic [XLEN-1:0] imm_source;
  logic            imm;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] res;
  logic            busy;

  modport master (
    output in_valid, reg_source1, reg_source2, imm_source, imm, funct3, funct7, out_ready,
    input  in_ready, out_valid, res, busy
  );

  modport slave (
    input  in_valid, reg_source1, reg_source2, imm_source, imm, funct3, funct7, out_ready,
    output in_ready, out_valid, res, busy
  );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned engine: shift-add multiply or restoring divide, one bit per cycle for XLEN cycles.
// Operands arrive as magnitudes; done_o flags the final step, whose value is on acc_nxt_o.
module alu_muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              is_div_i,
  input  logic [XLEN-1:0]   opa_i,
  input  logic [XLEN-1:0]   opb_i,
  output logic              done_o,
  output logic [2*XLEN-1:0] acc_nxt_o
);
  localparam int CNT_W = $clog2(XLEN);

  logic              run_q, run_d;
  logic              div_q, div_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   m_q, m_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN:0]     sum, rsh, diff;

  // acc holds {partial product, multiplier} for mul and {remainder, dividend/quotient} for div
  always_comb begin
    sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, m_q} : '0);
    rsh  = acc_q[2*XLEN-1:XLEN-1];
    diff = rsh - {1'b0, m_q};
    if (div_q) begin
      acc_nxt_o = diff[XLEN] ? {rsh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                             : {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      acc_nxt_o = {sum, acc_q[XLEN-1:1]};
    end
  end

  assign done_o = run_q && (cnt_q == '0);

  always_comb begin
    run_d = run_q;
    div_d = div_q;
    cnt_d = cnt_q;
    m_d   = m_q;
    acc_d = acc_q;
    if (start_i) begin
      run_d = 1'b1;
      div_d = is_div_i;
      cnt_d = CNT_W'(XLEN - 1);
      m_d   = is_div_i ? opb_i : opa_i;
      acc_d = {{XLEN{1'b0}}, (is_div_i ? opa_i : opb_i)};
    end else if (run_q) begin
      acc_d = acc_nxt_o;
      if (cnt_q == '0) run_d = 1'b0;
      else             cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q <= 1'b0;
      div_q <= 1'b0;
      cnt_q <= '0;
      m_q   <= '0;
      acc_q <= '0;
    end else begin
      run_q <= run_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
      m_q   <= m_d;
      acc_q <= acc_d;
    end
  end
endmodule

// File: rtl/alu_muldiv_seq.sv
// Registered RV32IM execute ALU: base ops and div-by-zero/overflow in 1 cycle, mul/div iterate XLEN cycles.
// Define ALU_FAST_MUL_EN to complete all multiplies in 1 cycle; result holds in DONE until out_ready.
import alu_pkg::*;

module alu_muldiv_seq #(
  parameter int XLEN = 32
) (
  input logic              clk,
  input logic              rst,
  alu_muldiv_seq_if.slave  bus
);
  localparam int SHAMT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q, state_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic              it_start, it_done;
  logic [2*XLEN-1:0] it_acc;

  logic [XLEN-1:0]    src1, src2, base_res, spec_res, a_mag, b_mag, calc_res;
  logic [SHAMT_W-1:0] shamt;
  logic               is_m, sgn_a, sgn_b, neg_a, neg_b, div_zero, div_ovf;
  logic [2*XLEN-1:0]  prod_s;

  assign src1  = bus.reg_source1;
  assign src2  = bus.imm ? bus.imm_source : bus.reg_source2;
  assign shamt = src2[SHAMT_W-1:0];
  assign is_m  = !bus.imm && (bus.funct7 == F7_MULDIV);

  always_comb begin
    base_res = '0;
    case (bus.funct3)
      F3_ADD:  base_res = (!bus.imm && bus.funct7 == F7_ALT) ? src1 - src2 : src1 + src2;
      F3_SLL:  base_res = src1 << shamt;
      F3_SLT:  base_res = {{(XLEN-1){1'b0}}, $signed(src1) < $signed(src2)};
      F3_SLTU: base_res = {{(XLEN-1){1'b0}}, src1 < src2};
      F3_XOR:  base_res = src1 ^ src2;
      F3_SR:   base_res = bus.funct7[5] ? XLEN'($signed(src1) >>> shamt) : src1 >> shamt;
      F3_OR:   base_res = src1 | src2;
      default: base_res = src1 & src2;
    endcase
  end

  // Signed M-ops run on magnitudes; the sign fix-up is applied once the engine finishes
  always_comb begin
    sgn_a    = (bus.funct3 == F3_MUL) || (bus.funct3 == F3_MULH) || (bus.funct3 == F3_MULHSU) ||
               (bus.funct3 == F3_DIV) || (bus.funct3 == F3_REM);
    sgn_b    = (bus.funct3 == F3_MUL) || (bus.funct3 == F3_MULH) ||
               (bus.funct3 == F3_DIV) || (bus.funct3 == F3_REM);
    neg_a    = sgn_a && src1[XLEN-1];
    neg_b    = sgn_b && src2[XLEN-1];
    a_mag    = neg_a ? -src1 : src1;
    b_mag    = neg_b ? -src2 : src2;
    div_zero = bus.funct3[2] && (src2 == '0);
    div_ovf  = ((bus.funct3 == F3_DIV) || (bus.funct3 == F3_REM)) && (src1 == XMIN) && (src2 == '1);
    if (div_zero) spec_res = bus.funct3[1] ? src1 : '1;
    else          spec_res = bus.funct3[1] ? '0 : XMIN;
  end

`ifdef ALU_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_a, fast_b, fast_p;
  logic [XLEN-1:0]   fast_res;
  assign fast_a   = {{XLEN{neg_a}}, src1};
  assign fast_b   = {{XLEN{neg_b}}, src2};
  assign fast_p   = fast_a * fast_b;
  assign fast_res = (bus.funct3 == F3_MUL) ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN];
`endif

  always_comb begin
    prod_s   = neg_q ? -it_acc : it_acc;
    calc_res = '0;
    case (op_q)
      F3_MUL:              calc_res = prod_s[XLEN-1:0];
      F3_DIV, F3_DIVU:     calc_res = neg_q ? -it_acc[XLEN-1:0] : it_acc[XLEN-1:0];
      F3_REM, F3_REMU:     calc_res = neg_q ? -it_acc[2*XLEN-1:XLEN] : it_acc[2*XLEN-1:XLEN];
      default:             calc_res = prod_s[2*XLEN-1:XLEN];
    endcase
  end

  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    op_d     = op_q;
    neg_d    = neg_q;
    it_start = 1'b0;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        state_d = DONE;
        if (!is_m) begin
          res_d = base_res;
        end else if (div_zero || div_ovf) begin
          res_d = spec_res;
`ifdef ALU_FAST_MUL_EN
        end else if (!bus.funct3[2]) begin
          res_d = fast_res;
`endif
        end else begin
          it_start = 1'b1;
          op_d     = bus.funct3;
          neg_d    = (bus.funct3[2] && bus.funct3[1]) ? neg_a : (neg_a ^ neg_b);
          state_d  = CALC;
        end
      end
      CALC: if (it_done) begin
        res_d   = calc_res;
        state_d = DONE;
      end
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      res_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
    end
  end

  alu_muldiv_iter #(.XLEN(XLEN)) u_iter (
    .clk       (clk),
    .rst       (rst),
    .start_i   (it_start),
    .is_div_i  (bus.funct3[2]),
    .opa_i     (a_mag),
    .opb_i     (b_mag),
    .done_o    (it_done),
    .acc_nxt_o (it_acc)
  );

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == CALC);
  assign bus.res       = res_q;
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed-vector bench for alu_muldiv_seq: driver queues expected results, a monitor checks them.
module tb_alu_muldiv_seq;
  import alu_pkg::*;

  localparam int XLEN = 32;
`ifdef ALU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = XLEN + 1;
`endif
  localparam int DIV_LAT = XLEN + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_muldiv_seq_if #(.XLEN(XLEN)) bus();
  alu_muldiv_seq #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [XLEN-1:0] res;
    int              lat;
    string           name;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   checks  = 0;
  int   errors  = 0;
  int   cyc     = 0;
  int   acc_cyc = 0;
  bit   prev_vld = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%h required=0x%h", nm, act, req);
    end
  endtask

  // Monitor: pops on the first cycle of each result, then checks it is held during backpressure
  always @(negedge clk) begin
    if (rst) begin
      prev_vld = 1'b0;
    end else begin
      if (bus.out_valid && !prev_vld) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result actual=0x%h required=no output", bus.res);
        end else begin
          cur = exp_q.pop_front();
          chk(cur.name, bus.res, cur.res);
          chk({cur.name, "_latency"}, XLEN'(cyc - acc_cyc), XLEN'(cur.lat));
        end
      end else if (bus.out_valid) begin
        chk({cur.name, "_held"}, bus.res, cur.res);
        chk({cur.name, "_in_ready_low"}, XLEN'(bus.in_ready), '0);
      end
      prev_vld = bus.out_valid;
    end
  end

  task automatic issue(input logic [2:0] f3, input logic [6:0] f7, input logic im,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic [XLEN-1:0] iv);
    int n = 0;
    @(negedge clk);
    bus.funct3      = f3;
    bus.funct7      = f7;
    bus.imm         = im;
    bus.reg_source1 = a;
    bus.reg_source2 = b;
    bus.imm_source  = iv;
    bus.in_valid    = 1'b1;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout actual=in_ready low required=in_ready high");
    end
    acc_cyc = cyc;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic op(input string nm, input logic [2:0] f3, input logic [6:0] f7, input logic im,
                    input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic [XLEN-1:0] iv,
                    input logic [XLEN-1:0] expv, input int lat, input int stall);
    int n = 0;
    exp_q.push_back('{expv, lat, nm});
    bus.out_ready = (stall == 0);
    issue(f3, f7, im, a, b, iv);
    while (!bus.out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.out_valid) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no out_valid required=out_valid", nm);
    end
    repeat (stall) @(negedge clk);
    bus.out_ready = 1'b1;
    n = 0;
    while (bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    bus.in_valid    = 1'b0;
    bus.out_ready   = 1'b1;
    bus.reg_source1 = '0;
    bus.reg_source2 = '0;
    bus.imm_source  = '0;
    bus.imm         = 1'b0;
    bus.funct3      = '0;
    bus.funct7      = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_out_valid", XLEN'(bus.out_valid), '0);
    chk("reset_busy",      XLEN'(bus.busy),      '0);
    chk("reset_in_ready",  XLEN'(bus.in_ready),  XLEN'(1));
    chk("reset_res",       bus.res,              '0);

    op("sub_reg",   F3_ADD,  F7_ALT,  1'b0, 32'd7, 32'd10, 32'd10, 32'hFFFFFFFD, 1, 0);
    op("add_imm",   F3_ADD,  F7_ALT,  1'b1, 32'd7, 32'd10, 32'd10, 32'd17,       1, 0);
    op("sra_shamt", F3_SR,   F7_ALT,  1'b0, 32'h80000000, 32'd33, 0, 32'hC0000000, 1, 0);
    op("srl",       F3_SR,   F7_BASE, 1'b0, 32'h80000000, 32'd33, 0, 32'h40000000, 1, 0);
    op("slli",      F3_SLL,  F7_BASE, 1'b1, 32'd1, 32'd0, 32'd36, 32'd16, 1, 0);
    op("slt",       F3_SLT,  F7_BASE, 1'b0, 32'hFFFFFFFF, 32'd1, 0, 32'd1, 1, 0);
    op("sltu",      F3_SLTU, F7_BASE, 1'b0, 32'hFFFFFFFF, 32'd1, 0, 32'd0, 1, 0);
    op("xor",       F3_XOR,  F7_BASE, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 0, 32'hFF00FF00, 1, 0);
    op("or",        F3_OR,   F7_BASE, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 0, 32'hFFF0FFF0, 1, 0);
    op("and",       F3_AND,  F7_BASE, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 0, 32'h00F000F0, 1, 0);
    op("imm_muldiv_is_add", F3_MUL, F7_MULDIV, 1'b1, 32'hFFFFFFFE, 32'd9, 32'd3, 32'd1, 1, 0);

    op("mul",       F3_MUL,    F7_MULDIV, 1'b0, 32'hFFFFFFFE, 32'd3, 0, 32'hFFFFFFFA, MUL_LAT, 0);
    op("mulh",      F3_MULH,   F7_MULDIV, 1'b0, 32'hFFFFFFFE, 32'd3, 0, 32'hFFFFFFFF, MUL_LAT, 0);
    op("mulhsu",    F3_MULHSU, F7_MULDIV, 1'b0, 32'hFFFFFFFE, 32'd3, 0, 32'hFFFFFFFF, MUL_LAT, 0);
    op("mulhu",     F3_MULHU,  F7_MULDIV, 1'b0, 32'hFFFFFFFE, 32'd3, 0, 32'd2,        MUL_LAT, 0);

    op("divu_by0",  F3_DIVU, F7_MULDIV, 1'b0, 32'd100, 32'd0, 0, 32'hFFFFFFFF, 1, 0);
    op("remu_by0",  F3_REMU, F7_MULDIV, 1'b0, 32'd100, 32'd0, 0, 32'd100,      1, 0);
    op("div_ovf",   F3_DIV,  F7_MULDIV, 1'b0, 32'h80000000, 32'hFFFFFFFF, 0, 32'h80000000, 1, 0);
    op("rem_ovf",   F3_REM,  F7_MULDIV, 1'b0, 32'h80000000, 32'hFFFFFFFF, 0, 32'd0,        1, 0);
    op("divu",      F3_DIVU, F7_MULDIV, 1'b0, 32'd100, 32'd7, 0, 32'd14, DIV_LAT, 0);
    op("remu",      F3_REMU, F7_MULDIV, 1'b0, 32'd100, 32'd7, 0, 32'd2,  DIV_LAT, 0);

    op("div_bp",    F3_DIV,  F7_MULDIV, 1'b0, 32'hFFFFFFF9, 32'd2, 0, 32'hFFFFFFFD, DIV_LAT, 5);
    op("rem_neg",   F3_REM,  F7_MULDIV, 1'b0, 32'hFFFFFFF9, 32'd2, 0, 32'hFFFFFFFF, DIV_LAT, 0);

    // Abandon a divide part-way: no result may ever appear for it
    issue(F3_DIVU, F7_MULDIV, 1'b0, 32'd1000, 32'd3, 32'd0);
    repeat (10) @(negedge clk);
    chk("busy_mid_calc", XLEN'(bus.busy), XLEN'(1));
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy",      XLEN'(bus.busy),      '0);
    chk("abort_out_valid", XLEN'(bus.out_valid), '0);
    chk("abort_in_ready",  XLEN'(bus.in_ready),  XLEN'(1));
    rst = 1'b0;
    repeat (40) @(negedge clk);
    op("add_after_abort", F3_ADD, F7_BASE, 1'b0, 32'd1, 32'd1, 0, 32'd2, 1, 0);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL pending_results actual=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
